// File: rtl/qdiv_pkg.sv
// Shared fixed-point definitions: word/fraction defaults used by the divider
// and the fixed-point multiplier, plus the divider state encoding.
package qdiv_pkg;

  localparam int FX_Q = 15;
  localparam int FX_N = 32;

  // Divider state encoding
  // state | meaning
  // IDLE  | waiting for i_start, outputs hold the last result
  // RUN   | one restoring-division iteration per cycle
  // DONE  | format/saturate the quotient, pulse o_done
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } qdiv_state_e;

endpackage

// File: rtl/qdiv.sv
// Sequential sign-magnitude fixed-point divider.
// Restoring division, one quotient bit per cycle, fixed latency of N+Q cycles
// from the accepting edge to o_done, with saturation on overflow/divide-by-zero.
//
// state | meaning
// IDLE  | waiting for i_start; o_quotient/ovr hold the previous result
// RUN   | N-1+Q iterations of shift/compare/subtract
// DONE  | register result and ovr, single-cycle o_done, back to IDLE
module qdiv
  import qdiv_pkg::*;
#(
  parameter int Q = FX_Q,
  parameter int N = FX_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_busy,
  output logic         o_done,
  output logic         ovr
);

  localparam int QW = N - 1 + Q;
  localparam int CW = $clog2(QW + 1);

  qdiv_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-2:0]  dvsr_q, dvsr_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  o_quotient_q, o_quotient_d;
  logic          ovr_q, ovr_d;
  logic          o_done_q, o_done_d;

  logic [N-1:0]  trial;
  logic [N:0]    sub;
  logic          take;
  logic          sat;
  logic [N-2:0]  mag;

  // Datapath: the single subtractor and the result formatting
  always_comb begin
    // quo_q doubles as the dividend shift register; its MSB feeds the remainder
    trial = {rem_q[N-2:0], quo_q[QW-1]};
    sub   = {1'b0, trial} - {2'b00, dvsr_q};
    // rem_q[N-1] is only ever set in the divide-by-zero case, whose result is overridden
    take  = rem_q[N-1] | ~sub[N];
    sat   = (dvsr_q == '0) | (|quo_q[QW-1:N-1]);
    mag   = sat ? '1 : quo_q[N-2:0];
  end

  // Next-state and register-input logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvsr_d       = dvsr_q;
    sign_d       = sign_q;
    o_quotient_d = o_quotient_q;
    ovr_d        = ovr_q;
    o_done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          dvsr_d  = i_divisor[N-2:0];
          sign_d  = i_dividend[N-1] ^ i_divisor[N-1];
          quo_d   = {i_dividend[N-2:0], {Q{1'b0}}};
          rem_d   = '0;
          cnt_d   = CW'(QW);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rem_d = take ? sub[N-1:0] : trial;
        quo_d = {quo_q[QW-2:0], take};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        o_quotient_d = {sign_q & (|mag), mag};
        ovr_d        = sat;
        o_done_d     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dvsr_q       <= '0;
      sign_q       <= 1'b0;
      o_quotient_q <= '0;
      ovr_q        <= 1'b0;
      o_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvsr_q       <= dvsr_d;
      sign_q       <= sign_d;
      o_quotient_q <= o_quotient_d;
      ovr_q        <= ovr_d;
      o_done_q     <= o_done_d;
    end
  end

  assign o_quotient = o_quotient_q;
  assign ovr        = ovr_q;
  assign o_done     = o_done_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule
